// File: rtl/booth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_pkg : shared types for the radix-4 Booth multiplier              |
// | Revision  : 1.0                                                        |
// +----------------------------------------------------------------------+
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    RUN    = 3'd3,
    OUT_HI = 3'd4,
    OUT_LO = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } op_t;

endpackage
`default_nettype wire

// File: rtl/booth_r4_recoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_r4_recoder : maps a 3-bit multiplier window to a Booth digit     |
// | Revision         : 1.0                                                 |
// +----------------------------------------------------------------------+
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] i_window,
  output op_t        o_op
);

  always_comb begin
    o_op = ZERO;
    case (i_window)
      3'b001, 3'b010: o_op = PM;
      3'b011:         o_op = P2M;
      3'b100:         o_op = N2M;
      3'b101, 3'b110: o_op = NM;
      default:        o_op = ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_r4_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_r4_mult : sequential radix-4 Booth multiplier, serial in/out     |
// | Option        : BOOTH_UNSIGNED_EN adds the uns port (unsigned mode)    |
// | Revision      : 1.0                                                    |
// +----------------------------------------------------------------------+
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic             uns,
`endif
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             final_beat,
  output logic             busy
);

  localparam int c_aw = WIDTH + 2;
`ifdef BOOTH_UNSIGNED_EN
  // Two spare multiplier bits let an unsigned operand be zero-extended.
  localparam int c_qw = WIDTH + 2;
`else
  localparam int c_qw = WIDTH;
`endif
  localparam int              c_cw   = $clog2(WIDTH / 2 + 2);
  localparam logic [c_cw-1:0] c_iter = c_cw'(WIDTH / 2);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  state_t              r_state;
  logic                r_start_d;
  logic [c_aw-1:0]     r_m;
  logic [c_aw-1:0]     r_a;
  logic [c_qw-1:0]     r_q;
  logic                r_qm1;
  logic [c_cw-1:0]     r_cnt;
`ifdef BOOTH_UNSIGNED_EN
  logic                r_uns;
`endif

  op_t                    w_op;
  logic [c_aw-1:0]        w_addend;
  logic [c_aw-1:0]        w_sum;
  logic signed [c_aw+c_qw:0] w_cat;
  logic signed [c_aw+c_qw:0] w_shift;
  logic [2*WIDTH-1:0]     w_prod;

  booth_r4_recoder u_recoder (
    .i_window ({r_q[1], r_q[0], r_qm1}),
    .o_op     (w_op)
  );

  always_comb begin
    w_addend = '0;
    case (w_op)
      PM:      w_addend = r_m;
      P2M:     w_addend = r_m << 1;
      NM:      w_addend = -r_m;
      N2M:     w_addend = -(r_m << 1);
      default: w_addend = '0;
    endcase
  end

  assign w_sum   = r_a + w_addend;
  assign w_cat   = {w_sum, r_q, r_qm1};
  assign w_shift = w_cat >>> 2;

`ifdef BOOTH_UNSIGNED_EN
  // Signed runs stop two bits short, leaving the sign-extension pair in r_q[1:0].
  assign w_prod = r_uns ? {r_a[WIDTH-3:0], r_q} : {r_a[WIDTH-1:0], r_q[c_qw-1:2]};
`else
  assign w_prod = {r_a[WIDTH-1:0], r_q};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_start_d <= 1'b0;
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
`ifdef BOOTH_UNSIGNED_EN
      r_uns     <= 1'b0;
`endif
    end else begin
      r_start_d <= start;
      case (r_state)
        IDLE: begin
          if (start && !r_start_d) r_state <= LOAD_M;
        end
        LOAD_M: begin
`ifdef BOOTH_UNSIGNED_EN
          r_uns <= uns;
          r_m   <= uns ? {2'b00, inbus} : {{2{inbus[WIDTH-1]}}, inbus};
`else
          r_m   <= {{2{inbus[WIDTH-1]}}, inbus};
`endif
          r_state <= LOAD_Q;
        end
        LOAD_Q: begin
`ifdef BOOTH_UNSIGNED_EN
          r_q   <= r_uns ? {2'b00, inbus} : {{2{inbus[WIDTH-1]}}, inbus};
          r_cnt <= r_uns ? c_iter + c_one : c_iter;
`else
          r_q   <= inbus;
          r_cnt <= c_iter;
`endif
          r_a     <= '0;
          r_qm1   <= 1'b0;
          r_state <= RUN;
        end
        RUN: begin
          r_a   <= w_shift[c_aw+c_qw:c_qw+1];
          r_q   <= w_shift[c_qw:1];
          r_qm1 <= w_shift[0];
          r_cnt <= r_cnt - c_one;
          if (r_cnt == c_one) r_state <= OUT_HI;
        end
        OUT_HI:  r_state <= OUT_LO;
        OUT_LO:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    outbus = '0;
    case (r_state)
      OUT_HI:  outbus = w_prod[2*WIDTH-1:WIDTH];
      OUT_LO:  outbus = w_prod[WIDTH-1:0];
      default: outbus = '0;
    endcase
  end

  assign busy       = (r_state != IDLE);
  assign out_valid  = (r_state == OUT_HI) || (r_state == OUT_LO);
  assign final_beat = (r_state == OUT_LO);

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_booth_r4_mult : directed + random checks against an arithmetic model|
// | Revision         : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_booth_r4_mult;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
  logic         uns   = 1'b0;
`endif
  logic [W-1:0] inbus = '0;
  logic [W-1:0] outbus;
  logic         out_valid;
  logic         final_beat;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  booth_r4_mult #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef BOOTH_UNSIGNED_EN
    .uns        (uns),
`endif
    .inbus      (inbus),
    .outbus     (outbus),
    .out_valid  (out_valid),
    .final_beat (final_beat),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Plain integer product, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                           input bit u);
    longint a, b;
    a = u ? longint'(m) : longint'($signed(m));
    b = u ? longint'(q) : longint'($signed(q));
    return (2*W)'(a * b);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge one cycle into IDLE.
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input bit u,
                       input bit hold);
    logic [2*W-1:0] exp_p;
    int             edge_n;
    bit             idle_dirty;
    exp_p = model(m, q, u);
    start = 1'b1;
    inbus = W'($urandom);
`ifdef BOOTH_UNSIGNED_EN
    uns = 1'($urandom);
`endif
    @(posedge clk); edge_n = 1;
    @(negedge clk);
    inbus = m;
    if (!hold) start = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
    uns = u;
`endif
    @(posedge clk); edge_n = 2;
    @(negedge clk);
    inbus = q;
`ifdef BOOTH_UNSIGNED_EN
    uns = 1'($urandom);
`endif
    @(posedge clk); edge_n = 3;
    @(negedge clk);
    inbus = W'($urandom);
    idle_dirty = 1'b0;
    while (!out_valid && edge_n < 40) begin
      if (outbus !== '0) idle_dirty = 1'b1;
      @(posedge clk); edge_n++;
      @(negedge clk); inbus = W'($urandom);
    end
    check("latency", 32'(edge_n), u ? 32'(W/2 + 4) : 32'(W/2 + 3));
    check("outbus_zero_when_invalid", 32'(idle_dirty), 32'd0);
    check("beat_hi", 32'(outbus), 32'(exp_p[2*W-1:W]));
    check("final_on_hi", 32'(final_beat), 32'd0);
    @(posedge clk); @(negedge clk);
    check("valid_lo", 32'(out_valid), 32'd1);
    check("beat_lo", 32'(outbus), 32'(exp_p[W-1:0]));
    check("final_on_lo", 32'(final_beat), 32'd1);
    @(posedge clk); @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_outbus", 32'(outbus), 32'd0);
  endtask

  initial begin
    bit stray;
    logic [W-1:0] dm [6] = '{8'd6, 8'hFD, 8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [W-1:0] dq [6] = '{8'd8, 8'd5, 8'h80, 8'h80, 8'h5A, 8'hFF};

    // Reset state
    #1;
    check("rst_outbus", 32'(outbus), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_final", 32'(final_beat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed operands (6*8, -3*5, -128*-128, 127*-128, 0*x, -1*-1), back-to-back
    for (int i = 0; i < 6; i++) do_op(dm[i], dq[i], 1'b0, 1'b0);

    // start held high for 20 cycles: one product only
    do_op(8'd11, 8'd13, 1'b0, 1'b1);
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || out_valid) stray = 1'b1;
    end
    check("held_start_no_retrigger", 32'(stray), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Reset during the third RUN cycle
    start = 1'b1; inbus = W'($urandom);
    @(negedge clk); start = 1'b0; inbus = 8'd7;
    @(negedge clk); inbus = 8'd9;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_outbus", 32'(outbus), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_final", 32'(final_beat), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid || busy) stray = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid || busy) stray = 1'b1;
    end
    check("midrst_no_beats", 32'(stray), 32'd0);
    do_op(8'd2, 8'd3, 1'b0, 1'b0);

    // Random signed operands
    for (int i = 0; i < 10; i++) do_op(W'($urandom), W'($urandom), 1'b0, 1'b0);

`ifdef BOOTH_UNSIGNED_EN
    do_op(8'd255, 8'd255, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_r4_mult.md
BOOTH_R4_MULT -- requirements
Module: booth_r4_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and at least 4.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  operation request, rising-edge qualified.
REQ-005 The block SHALL have port inbus  input  WIDTH  serial operand bus: multiplicand first, multiplier second.
REQ-006 The block SHALL have port outbus  output  WIDTH  product beat: high half first, then low half.
REQ-007 The block SHALL have port out_valid  output  1  high while outbus carries a product beat.
REQ-008 The block SHALL have port final  output  1  high for exactly the cycle carrying the last (low) beat.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 FSM states SHALL be IDLE, LOAD_M, LOAD_Q, RUN, OUT_HI and OUT_LO; busy, out_valid and final SHALL decode from the registered state only.
REQ-011 IDLE->LOAD_M SHALL occur on the edge where start=1 and the registered previous start=0; start held high SHALL NOT retrigger.
REQ-012 LOAD_M edge SHALL capture inbus as M (sign-extended to WIDTH+2 bits); LOAD_Q edge SHALL capture inbus as Q, clear A (WIDTH+2 bits) and Q[-1], and load the iteration counter with WIDTH/2.
REQ-013 Each RUN edge SHALL recode {Q[1],Q[0],Q[-1]}: 000/111 -> +0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M; the sum is added into A, then {A,Q,Q[-1]} is arithmetic-shifted right 2 and the counter decremented.
REQ-014 RUN->OUT_HI SHALL occur on the edge that decrements the counter to 0; OUT_HI->OUT_LO and OUT_LO->IDLE SHALL each take one edge.
REQ-015 Product P SHALL be the 2*WIDTH-bit two's-complement value {A[WIDTH-1:0],Q}; OUT_HI drives P[2W-1:W], OUT_LO drives P[W-1:0] with final=1.
REQ-016 Latency from start-qualifying edge to the first out_valid cycle SHALL be WIDTH/2+3 edges (7 for WIDTH=8).
REQ-017 start and inbus SHALL be ignored in every state other than IDLE, LOAD_M and LOAD_Q respectively as listed in REQ-011 and REQ-012.
REQ-018 outbus SHALL be 0 whenever out_valid=0.
REQ-019 M=Q=-2^(WIDTH-1) SHALL produce +2^(2*WIDTH-2) exactly; A SHALL not overflow for -2M.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE, clear M, Q, A, Q[-1], counter and the previous-start register, and drive outbus=0, out_valid=0, final=0, busy=0.
REQ-021 Reset asserted mid-operation SHALL abandon it with no output beat; after release a fresh start rising edge is required.

Configuration
REQ-022 With macro BOOTH_UNSIGNED_EN defined, the block SHALL add input port uns (1 bit), sampled on the LOAD_M edge; uns=1 zero-extends M and Q and runs WIDTH/2+1 RUN iterations, giving latency WIDTH/2+4.
REQ-023 Without BOOTH_UNSIGNED_EN, port uns SHALL be absent and all operations SHALL be signed.

Structure
REQ-024 Package booth_pkg SHALL hold the state enum typedef and the recode-operation typedef (ZERO, PM, P2M, NM, N2M).
REQ-025 Sub-module booth_r4_recoder SHALL be combinational, mapping the 3-bit window to the recode operation; all registers SHALL reside in booth_r4_mult.

Verification (WIDTH=8)
REQ-026 M=6, Q=8 -> outbus 0x00 then 0x30, final on the second beat, first beat at edge 7.
REQ-027 M=-3, Q=5 -> 0xFF then 0xF1; M=-128, Q=-128 -> 0x40 then 0x00.
REQ-028 start held high for 20 cycles -> exactly one product, busy low afterward.
REQ-029 reset pulled low during the third RUN cycle -> all outputs 0 immediately, no beats, restart with M=2, Q=3 -> 0x00 then 0x06.
REQ-030 With BOOTH_UNSIGNED_EN, uns=1, M=255, Q=255 -> 0xFE then 0x01 at edge 8.
REQ-031 Back-to-back: start lowered during OUT_LO and raised the cycle after IDLE is entered -> second operation accepted with correct product.
